// File: rtl/emit_pkg.sv
// -----------------------------------------------------------------------------
// emit_pkg
// Shared definitions for the emit0 control block and its counter datapath:
//   - emit_state_e : controller FSM states
//   - CMD_*        : command codes driven on {cnt0_ld, cnt0_clr, cnt0_ACK}
//   - EMIT_CNT     : default count the datapath loads on a LOAD command
//   - cmd_for_state: command the controller registers when entering a state
// -----------------------------------------------------------------------------
package emit_pkg;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_IDLE   = 4'd1,
        ST_LOAD   = 4'd2,
        ST_SETTLE = 4'd3,
        ST_PACE   = 4'd4,
        ST_ACK    = 4'd5,
        ST_CHECK  = 4'd6,
        ST_DONE   = 4'd7,
        ST_FAULT  = 4'd8,
        ST_ABORT  = 4'd9
    } emit_state_e;

    // Bit order is {ld, clr, ACK}; a decrement is a load qualified by ACK.
    localparam logic [2:0] CMD_HOLD = 3'b000;
    localparam logic [2:0] CMD_LOAD = 3'b100;
    localparam logic [2:0] CMD_DEC  = 3'b101;
    localparam logic [2:0] CMD_CLR  = 3'b010;

    localparam int EMIT_CNT = 5;

    // Commands are registered on entry to a state, so they are visible for
    // exactly the cycle the FSM spends in that state.
    function automatic logic [2:0] cmd_for_state(input emit_state_e st);
        logic [2:0] cmd;
        case (st)
            ST_INIT, ST_FAULT, ST_ABORT: cmd = CMD_CLR;
            ST_LOAD:                     cmd = CMD_LOAD;
            ST_ACK:                      cmd = CMD_DEC;
            default:                     cmd = CMD_HOLD;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/emit0_pace_timer.sv
// -----------------------------------------------------------------------------
// emit0_pace_timer
// Loadable down-counter pacing decrement commands. Loads PERIOD-1 so that a
// countdown to zero spans exactly PERIOD cycles; holds at zero (no wrap).
// Ports:
//   clk     rising-edge clock
//   i_rst   synchronous active-high reset (count -> 0)
//   i_load  reload PERIOD-1 (priority over i_dec)
//   i_dec   decrement by one if not already zero
//   o_zero  count == 0
// -----------------------------------------------------------------------------
module emit0_pace_timer #(
    parameter int PERIOD = 4,
    parameter int W      = $clog2(PERIOD + 1)
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam logic [W-1:0] RELOAD = W'(PERIOD - 1);

    logic [W-1:0] r_cnt;

    // Countdown register: reload has priority, decrement stops at zero.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_cnt <= {W{1'b0}};
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (i_dec && (r_cnt != {W{1'b0}})) begin
            r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/emit0_ctrl.sv
// -----------------------------------------------------------------------------
// emit0_ctrl
// Control-side initiator for the emit0 counter datapath. On start it loads the
// emit count, then issues paced decrement commands until the datapath reports
// zero. Handles abort, runaway/failed-load faults and datapath initialisation.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, abort             single-cycle requests
//   eq_0, out0               datapath status (count==0, emit-active)
//   cnt0_ld/cnt0_clr/cnt0_ACK registered datapath command lines
//   busy, done, err          status: not idle, completion pulse, sticky fault
// -----------------------------------------------------------------------------
module emit0_ctrl
    import emit_pkg::*;
#(
    parameter int ACK_PERIOD = 4,
    parameter int MAX_ACKS   = 15,
    parameter int PEND_EN    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic eq_0,
    input  logic out0,
    output logic cnt0_ld,
    output logic cnt0_clr,
    output logic cnt0_ACK,
    output logic busy,
    output logic done,
    output logic err
);

    localparam logic [3:0] MAX_ACKS_4 = 4'(MAX_ACKS);

    emit_state_e r_state;
    emit_state_e w_next;
    logic [2:0]  r_cmd;
    logic [3:0]  r_ack_cnt;
    logic        r_pending;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        w_timer_load;
    logic        w_timer_dec;
    logic        w_timer_zero;

    emit0_pace_timer #(
        .PERIOD (ACK_PERIOD)
    ) u_pace_timer (
        .clk    (clk),
        .i_rst  (rst),
        .i_load (w_timer_load),
        .i_dec  (w_timer_dec),
        .o_zero (w_timer_zero)
    );

    // Next-state and pace-timer control.
    always_comb begin
        w_next       = r_state;
        w_timer_load = 1'b0;
        w_timer_dec  = 1'b0;
        case (r_state)
            // Stay until CLEAR has actually been presented for one cycle;
            // the reset cycle itself drives HOLD.
            ST_INIT: begin
                if (r_cmd == CMD_CLR) w_next = ST_IDLE;
                else                  w_next = ST_INIT;
            end
            ST_IDLE: begin
                if (start && !abort) w_next = ST_LOAD;
                else                 w_next = ST_IDLE;
            end
            ST_LOAD: begin
                if (abort) w_next = ST_ABORT;
                else       w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_next = ST_ABORT;
                end else if (eq_0 || !out0) begin
                    w_next = ST_FAULT;
                end else begin
                    w_next       = ST_PACE;
                    w_timer_load = 1'b1;
                end
            end
            ST_PACE: begin
                if (abort) begin
                    w_next = ST_ABORT;
                end else if (w_timer_zero) begin
                    w_next = ST_ACK;
                end else begin
                    w_next      = ST_PACE;
                    w_timer_dec = 1'b1;
                end
            end
            ST_ACK: begin
                if (abort) w_next = ST_ABORT;
                else       w_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (abort) begin
                    w_next = ST_ABORT;
                end else if (eq_0) begin
                    w_next = ST_DONE;
                end else if (r_ack_cnt == MAX_ACKS_4) begin
                    w_next = ST_FAULT;
                end else begin
                    w_next       = ST_PACE;
                    w_timer_load = 1'b1;
                end
            end
            ST_DONE: begin
                if (r_pending) w_next = ST_LOAD;
                else           w_next = ST_IDLE;
            end
            ST_FAULT: w_next = ST_IDLE;
            ST_ABORT: w_next = ST_IDLE;
            default:  w_next = ST_INIT;
        endcase
    end

    // State, registered outputs, ack counter, pending latch and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_cmd     <= CMD_HOLD;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_pending <= 1'b0;
            r_ack_cnt <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cmd   <= cmd_for_state(w_next);
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);

            if (w_next == ST_FAULT) begin
                r_err <= 1'b1;
            end else if ((r_state == ST_IDLE) && (w_next == ST_LOAD)) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end

            if (w_next == ST_LOAD) begin
                r_ack_cnt <= 4'd0;
            end else if ((w_next == ST_ACK) && (r_ack_cnt != 4'd15)) begin
                r_ack_cnt <= r_ack_cnt + 4'd1;
            end else begin
                r_ack_cnt <= r_ack_cnt;
            end

            // A start that is about to be consumed, or that coincides with an
            // abort, never lands in the pending latch.
            if ((w_next == ST_LOAD) || (r_state == ST_FAULT) || (r_state == ST_ABORT)) begin
                r_pending <= 1'b0;
            end else if ((PEND_EN != 0) && start && (r_state != ST_IDLE) &&
                         (w_next != ST_ABORT) && (w_next != ST_FAULT)) begin
                r_pending <= 1'b1;
            end else begin
                r_pending <= r_pending;
            end
        end
    end

    assign {cnt0_ld, cnt0_clr, cnt0_ACK} = r_cmd;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: doc/emit0_ctrl.md
Name: emit0_ctrl

Overview:
- Control-side initiator for the emit0 counter datapath. Drives its load/clear/ACK command lines and consumes its eq_0/out0 status.
- On a dispense request, it loads the emit count, then issues paced decrement (ACK) commands until the datapath reports zero.
- Reports busy, done and error to the top-level dispenser FSM.
- Also handles abort, fault and datapath initialisation after reset.

Parameters:
- ACK_PERIOD, 4: idle cycles in PACE between consecutive decrement commands; legal range ≥1.
- MAX_ACKS, 15: maximum decrement commands per dispense before declaring a fault; legal range 1..15.
- PEND_EN, 1: 1 latches one start received while busy; 0 ignores it.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle dispense request
- abort  in  1  single-cycle abort request
- eq_0  in  1  datapath count==0 (combinational from datapath register)
- out0  in  1  datapath emit-active flag
- cnt0_ld  out  1  datapath load / decrement qualifier
- cnt0_clr  out  1  datapath clear
- cnt0_ACK  out  1  datapath decrement qualifier
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky fault flag

Behaviour:
- Command encoding on {cnt0_ld,cnt0_clr,cnt0_ACK}, all registered outputs:
  - LOAD = 100
  - DECREMENT = 101
  - CLEAR = 010
  - HOLD = 000
  - No other code is ever driven.
- Reset: state=INIT, all outputs 0, pending=0, err=0, ack_cnt=0, pace timer=0.
- States and transitions:
  - INIT: drive CLEAR for 1 cycle, then IDLE. The datapath has no reset, so this puts it in a known state after every rst.
  - IDLE: HOLD, busy=0. If start=1 and abort=0, clear err, ack_cnt=0, go to LOAD.
  - LOAD: drive LOAD for 1 cycle, then SETTLE.
  - SETTLE: HOLD. If eq_0=1 or out0=0, go to FAULT (failed load). Otherwise timer=ACK_PERIOD-1, go to PACE.
  - PACE: HOLD, decrement timer. When timer==0, go to ACK. PACE therefore lasts exactly ACK_PERIOD cycles.
  - ACK: drive DECREMENT for 1 cycle, ack_cnt+=1, then CHECK.
  - CHECK: HOLD. eq_0 now reflects the post-decrement count.
    - eq_0=1: go to DONE.
    - else if ack_cnt==MAX_ACKS: go to FAULT.
    - else reload timer and go to PACE.
  - DONE: done=1 for 1 cycle. Go to LOAD if pending=1 (clearing pending), else IDLE.
  - FAULT: drive CLEAR 1 cycle, set err=1, clear pending, then IDLE.
  - ABORT: drive CLEAR 1 cycle, clear pending, then IDLE. No done, err unchanged.
- Abort rules:
  - abort=1 in LOAD/SETTLE/PACE/ACK/CHECK goes to ABORT next cycle; a command already registered this cycle still completes.
  - abort in DONE, FAULT, INIT or IDLE is ignored.
  - abort has priority over start in the same cycle.
- start rules:
  - start while busy, with PEND_EN=1, sets pending. A second start while pending is already set is dropped.
  - With PEND_EN=0, start while busy is ignored.
- err is sticky until the next accepted start or rst.
- ack_cnt is 4 bits and saturates at 15. The pace timer is $clog2(ACK_PERIOD+1) bits with no wrap; it is reloaded on each entry to PACE.
- rst mid-operation returns to INIT, which reissues CLEAR. Outputs are 0 in the reset cycle.
- Latency for an N-count dispense: done asserts 2 + N×(ACK_PERIOD+2) + 1 cycles after the start-sampling edge.

Decomposition:
- Shared package emit_pkg holds:
  - state enum (INIT, IDLE, LOAD, SETTLE, PACE, ACK, CHECK, DONE, FAULT, ABORT)
  - command localparams CMD_HOLD, CMD_LOAD, CMD_DEC, CMD_CLR
  - default EMIT_CNT=5, shared with the datapath
- One sub-module, emit0_pace_timer: loadable down-counter with a zero flag. The FSM, pending latch and ack_cnt stay in emit0_ctrl.

Test Plan:
- Bench pairs emit0_ctrl with the emit0 datapath (EMIT_CNT=5, ACK_PERIOD=4).
- Reset then idle: rst 2 cycles → one CLEAR cycle, then IDLE. Outputs 0, datapath eq_0=1.
- Nominal dispense: start at edge 0 → LOAD cycle 1; DECREMENT at cycles 7, 13, 19, 25, 31; done pulse cycle 33. Exactly 5 decrements, err=0.
- Abort: start, then abort at cycle 15 (PACE) → CLEAR at cycle 16, IDLE at 17. No done, datapath eq_0=1, err=0.
- Load fault: datapath with EMIT_CNT=0 → SETTLE sees eq_0=1, then FAULT CLEAR. err=1 until next start, no done.
- Runaway: MAX_ACKS=3 with EMIT_CNT=5 → 3 decrements, then FAULT. err=1, final count cleared to 0.
- Pending: second start at cycle 10, PEND_EN=1 → done at 33, LOAD at 34, second done at 66. A third start during the run is dropped.
